// File: rtl/pid_incr_calc.sv
// pid_incr_calc
// Incremental PID back end for the ball-tracking servo loop. Takes the error
// triple e(k), e(k-1), e(k-2) and computes
//   du = Kp*(e0-e1) + Ki*e0 + Kd*(e0-2*e1+e2)
// with one shared multiplier over a 4-cycle sequence. It then accumulates
// u(k) = clamp(u(k-1) + (du >>> FRAC_BITS), U_MIN, U_MAX).
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   sample_valid       one-cycle strobe, ek0/ek1/ek2 hold a new sample
//   ek0, ek1, ek2      signed 10-bit errors e(k), e(k-1), e(k-2)
//   kp, ki, kd         unsigned 8-bit gains, FRAC_BITS fractional bits
//   clr                synchronous clear of accumulator and sequence
//   busy               high while a computation is in progress
//   u                  saturated signed control word, held between updates
//   u_valid            one-cycle pulse when u has been updated
//   dbg_state          current sequencer state
//
// Handshake: a sample is accepted only on a cycle with sample_valid=1 and
// busy=0. A strobe while busy=1 is dropped; there is no queuing and no
// back-pressure. The u_valid cycle already has busy=0, so a strobe in that
// cycle is accepted.
module pid_incr_calc #(
  parameter int FRAC_BITS = 4,
  parameter int U_W       = 16,
  parameter int U_MAX     = 500,
  parameter int U_MIN     = -500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic signed [9:0]     ek0,
  input  logic signed [9:0]     ek1,
  input  logic signed [9:0]     ek2,
  input  logic        [7:0]     kp,
  input  logic        [7:0]     ki,
  input  logic        [7:0]     kd,
  input  logic                  clr,
  output logic                  busy,
  output logic signed [U_W-1:0] u,
  output logic                  u_valid,
  output logic        [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_P = 3'd1,
    MUL_I = 3'd2,
    MUL_D = 3'd3,
    ACC   = 3'd4
  } state_t;

  state_t                state_q;
  logic signed [10:0]    dp_q;
  logic signed [9:0]     di_q;
  logic signed [11:0]    dd_q;
  logic        [7:0]     kp_q, ki_q, kd_q;
  logic signed [22:0]    sum_q;
  logic signed [U_W-1:0] u_q;
  logic                  u_valid_q;

  // Operand preparation from the raw inputs, latched when IDLE accepts a sample.
  // dd spans +-2046 at most, so 12 bits never overflow.
  logic signed [10:0] dp_d;
  logic signed [11:0] dd_d;
  always_comb begin
    dp_d = {ek0[9], ek0} - {ek1[9], ek1};
    dd_d = {{2{ek0[9]}}, ek0} - {ek1[9], ek1, 1'b0} + {{2{ek2[9]}}, ek2};
  end

  // Shared multiplier. The state selects which operand/gain pair is multiplied.
  // Each gain is zero-extended so the product stays a signed multiply.
  logic signed [11:0] mul_a;
  logic        [7:0]  mul_g;
  logic signed [20:0] a_ext, g_ext, prod;
  logic signed [22:0] prod_ext;
  always_comb begin
    mul_a = '0;
    mul_g = '0;
    case (state_q)
      MUL_P:   begin mul_a = {dp_q[10], dp_q};        mul_g = kp_q; end
      MUL_I:   begin mul_a = {{2{di_q[9]}}, di_q};    mul_g = ki_q; end
      MUL_D:   begin mul_a = dd_q;                    mul_g = kd_q; end
      default: begin mul_a = '0;                      mul_g = '0;   end
    endcase
    a_ext    = {{9{mul_a[11]}}, mul_a};
    g_ext    = {13'd0, mul_g};
    prod     = a_ext * g_ext;
    prod_ext = {{2{prod[20]}}, prod};
  end

  // Accumulate step. The arithmetic shift floors toward -inf.
  // The sum is formed at 32 bits so that the clamp sees the true value before
  // any truncation. The saturated value is stored back, which gives anti-windup.
  logic signed [22:0]    delta;
  logic signed [31:0]    t_sum;
  logic signed [U_W-1:0] u_sat;
  always_comb begin
    delta = sum_q >>> FRAC_BITS;
    t_sum = {{9{delta[22]}}, delta} + {{(32-U_W){u_q[U_W-1]}}, u_q};
    if (t_sum > U_MAX)
      u_sat = U_W'(U_MAX);
    else if (t_sum < U_MIN)
      u_sat = U_W'(U_MIN);
    else
      u_sat = t_sum[U_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dp_q      <= '0;
      di_q      <= '0;
      dd_q      <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      sum_q     <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
    end else if (clr) begin
      // clr beats everything, including a coincident sample_valid.
      state_q   <= IDLE;
      sum_q     <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
    end else begin
      u_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            dp_q    <= dp_d;
            di_q    <= ek0;
            dd_q    <= dd_d;
            kp_q    <= kp;
            ki_q    <= ki;
            kd_q    <= kd;
            sum_q   <= '0;
            state_q <= MUL_P;
          end
        end
        MUL_P: begin
          sum_q   <= prod_ext;
          state_q <= MUL_I;
        end
        MUL_I: begin
          sum_q   <= sum_q + prod_ext;
          state_q <= MUL_D;
        end
        MUL_D: begin
          sum_q   <= sum_q + prod_ext;
          state_q <= ACC;
        end
        ACC: begin
          u_q       <= u_sat;
          u_valid_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign u         = u_q;
  assign u_valid   = u_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pid_incr_calc.sv
// Bench for pid_incr_calc. A table of samples with hand-computed u values is
// run back to back from reset. Sequences then cover clear, the floor behaviour,
// dropped strobes, a strobe that coincides with u_valid, and a mid-sequence reset.
module tb_pid_incr_calc;

  logic               clk;
  logic               rst;
  logic               sample_valid;
  logic signed [9:0]  ek0, ek1, ek2;
  logic        [7:0]  kp, ki, kd;
  logic               clr;
  logic               busy;
  logic signed [15:0] u;
  logic               u_valid;
  logic        [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  pid_incr_calc #(
    .FRAC_BITS(4),
    .U_W(16),
    .U_MAX(500),
    .U_MIN(-500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .ek0(ek0),
    .ek1(ek1),
    .ek2(ek2),
    .kp(kp),
    .ki(ki),
    .kd(kd),
    .clr(clr),
    .busy(busy),
    .u(u),
    .u_valid(u_valid),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [9:0] e0, e1, e2;
    logic        [7:0] gp, gi, gd;
    int                exp_u;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int c,
                              input int p, input int i, input int d, input int x);
    vec_t v;
    v.e0 = 10'(a); v.e1 = 10'(b); v.e2 = 10'(c);
    v.gp = 8'(p);  v.gi = 8'(i);  v.gd = 8'(d);
    v.exp_u = x;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Driver tasks. They are called at a negedge and return at the negedge that
  // follows the accepting edge.
  task automatic strobe(input int a, input int b, input int c,
                        input int p, input int i, input int d);
    ek0 = 10'(a); ek1 = 10'(b); ek2 = 10'(c);
    kp = 8'(p); ki = 8'(i); kd = 8'(d);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Counts the edges after acceptance until u_valid is seen. The wait is bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!u_valid && lat < 12);
  endtask

  vec_t vecs[8];
  int   lat;
  int   pulses;
  int   seen_u;

  initial begin
    // Expected u values accumulate across rows, starting from u=0 after reset.
    vecs[0] = mk(  10,    0,    0,  16,  4,  8,   17); // sum 280 -> 17
    vecs[1] = mk(  10,   10,    0,  16,  4,  8,   14); // sum -40 -> -3
    vecs[2] = mk(  -1,    0,    0,   0,  1,  0,   13); // sum -1 -> -1
    vecs[3] = mk( 511, -512,    0, 255,  0,  0,  500); // +16304, clamps high
    vecs[4] = mk(-512,  511,    0, 255,  0,  0, -500); // -16305, clamps low
    vecs[5] = mk(-512,  511,    0, 255,  0,  0, -500); // stays clamped
    vecs[6] = mk(   3,   -2,    1,  16, 16, 16, -484); // 80+48+128=256 -> 16
    vecs[7] = mk( 511, -512,  511,   0,  0,  1, -357); // dd=2046 -> 127

    rst = 1'b1; clr = 1'b0; sample_valid = 1'b0;
    ek0 = '0; ek1 = '0; ek2 = '0; kp = '0; ki = '0; kd = '0;
    repeat (3) @(negedge clk);
    check("reset_u", int'(u), 0);
    check("reset_u_valid", int'(u_valid), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven samples
    for (int i = 0; i < 8; i++) begin
      strobe(int'(vecs[i].e0), int'(vecs[i].e1), int'(vecs[i].e2),
             int'(vecs[i].gp), int'(vecs[i].gi), int'(vecs[i].gd));
      check($sformatf("vec%0d_busy", i), int'(busy), 1);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_u", i), int'(u), vecs[i].exp_u);
      @(negedge clk);
      check($sformatf("vec%0d_pulse_end", i), int'(u_valid), 0);
      check($sformatf("vec%0d_u_held", i), int'(u), vecs[i].exp_u);
      check($sformatf("vec%0d_idle", i), int'(busy), 0);
    end

    // Clear, including a clear coincident with a strobe
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_u", int'(u), 0);
    strobe(10, 0, 0, 16, 4, 8);
    wait_valid(lat);
    check("clr_pre_u", int'(u), 17);
    @(negedge clk);
    clr = 1'b1;
    ek0 = 10'sd10; ek1 = '0; ek2 = '0; kp = 8'd16; ki = 8'd4; kd = 8'd8;
    sample_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    sample_valid = 1'b0;
    check("clr_sv_u", int'(u), 0);
    check("clr_sv_busy", int'(busy), 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (u_valid) pulses++;
      if (busy) pulses++;
      @(negedge clk);
    end
    check("clr_sv_no_activity", pulses, 0);

    // Floor toward -inf from u=0
    strobe(-1, 0, 0, 0, 1, 0);
    wait_valid(lat);
    check("floor_u", int'(u), -1);
    @(negedge clk);

    // A second strobe two cycles in is dropped
    strobe(10, 0, 0, 16, 4, 8);
    @(negedge clk);
    strobe(511, -512, 0, 255, 0, 0);
    pulses = 0;
    seen_u = 9999;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (u_valid) begin
        pulses++;
        seen_u = int'(u);
      end
    end
    check("drop_pulses", pulses, 1);
    check("drop_u", seen_u, 16);
    check("drop_final_u", int'(u), 16);

    // A strobe in the u_valid cycle is accepted
    strobe(10, 0, 0, 16, 4, 8);
    wait_valid(lat);
    check("coinc_first_u", int'(u), 33);
    strobe(10, 0, 0, 16, 4, 8);
    check("coinc_busy", int'(busy), 1);
    wait_valid(lat);
    check("coinc_latency", lat, 4);
    check("coinc_u", int'(u), 50);

    // Reset asserted while in MUL_I
    strobe(10, 0, 0, 16, 4, 8);
    @(negedge clk);
    check("pre_rst_state", int'(dbg_state), 2);
    #2 rst = 1'b1;
    #1;
    check("midrst_u", int'(u), 0);
    check("midrst_u_valid", int'(u_valid), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    strobe(10, 0, 0, 16, 4, 8);
    wait_valid(lat);
    check("postrst_latency", lat, 4);
    check("postrst_u", int'(u), 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
